// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing constants and the AGU state encoding
package fft_pkg;

    localparam int L  = 11;
    localparam int N  = 1 << L;
    localparam int LW = $clog2(L);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} agu_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - reset-clearable shift register for the write-back path
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - in-place radix-2 DIT FFT address generator and level sequencer
module fft_agu #(
    parameter int L             = fft_pkg::L,
    parameter int BUTTERFLY_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(L)-1:0] level,
    output logic                 rd_en,
    output logic [L-1:0]         rd_addr_a,
    output logic [L-1:0]         rd_addr_b,
    output logic [L-2:0]         tw_addr,
    output logic                 wr_en,
    output logic [L-1:0]         wr_addr_a,
    output logic [L-1:0]         wr_addr_b
);

    import fft_pkg::*;

    localparam int LW = $clog2(L);
    localparam int CW = $clog2(BUTTERFLY_LAT) + 1;
    localparam int DW = 1 + 2 * L;
    localparam logic [L-2:0]  I_LAST = '1;
    localparam logic [LW-1:0] S_LAST = LW'(L - 1);
    localparam logic [L-1:0]  ONE_L  = L'(1);

    agu_state_t      r_state;
    logic [LW-1:0]   r_s;
    logic [L-2:0]    r_i;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [L-1:0]    r_rd_a;
    logic [L-1:0]    r_rd_b;
    logic [L-2:0]    r_tw;

    logic [LW-1:0]   w_sel_s;
    logic [L-2:0]    w_sel_i;
    logic [L-1:0]    w_mask;
    logic [L-1:0]    w_ie;
    logic [L-1:0]    w_addr_a;
    logic [L-1:0]    w_addr_b;
    logic [L-1:0]    w_tw_full;
    logic [DW-1:0]   w_dl_out;

    // Select the butterfly that the next clock edge will present on the read port.
    always_comb begin
        w_sel_s = r_s;
        w_sel_i = r_i + (L-1)'(1);
        if (r_state != RUN) begin
            w_sel_i = '0;
            w_sel_s = (r_state == DRAIN) ? r_s + LW'(1) : '0;
        end
    end

    always_comb begin
        w_mask    = (ONE_L << w_sel_s) - ONE_L;
        w_ie      = {1'b0, w_sel_i};
        w_addr_a  = ((w_ie & ~w_mask) << 1) | (w_ie & w_mask);
        w_addr_b  = w_addr_a | (ONE_L << w_sel_s);
        w_tw_full = (w_ie & w_mask) << (L - 1 - int'(w_sel_s));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_i     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_s     <= '0;
                        r_i     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_addr_a;
                        r_rd_b  <= w_addr_b;
                        r_tw    <= w_tw_full[L-2:0];
                    end
                end
                RUN: begin
                    if (r_i == I_LAST) begin
                        r_state <= DRAIN;
                        r_cnt   <= CW'(BUTTERFLY_LAT - 1);
                        r_rd_en <= 1'b0;
                        r_rd_a  <= '0;
                        r_rd_b  <= '0;
                        r_tw    <= '0;
                    end else begin
                        r_i    <= w_sel_i;
                        r_rd_a <= w_addr_a;
                        r_rd_b <= w_addr_b;
                        r_tw   <= w_tw_full[L-2:0];
                    end
                end
                DRAIN: begin
                    // The gap lets the level's last write-back land before the next level reads it.
                    if (r_cnt == '0) begin
                        if (r_s == S_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_s     <= w_sel_s;
                            r_i     <= '0;
                            r_rd_en <= 1'b1;
                            r_rd_a  <= w_addr_a;
                            r_rd_b  <= w_addr_b;
                            r_tw    <= w_tw_full[L-2:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_s     <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fft_delay_line #(
        .WIDTH (DW),
        .DEPTH (BUTTERFLY_LAT)
    ) u_wb_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  ({r_rd_en, r_rd_a, r_rd_b}),
        .o_data  (w_dl_out)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign level     = r_s;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_addr   = r_tw;
    assign wr_en     = w_dl_out[DW-1];
    assign wr_addr_a = w_dl_out[2*L-1:L];
    assign wr_addr_b = w_dl_out[L-1:0];

endmodule

// File: tb/tb_fft_agu.sv
// tb/tb_fft_agu.sv - directed self-checking bench for fft_agu (L=3/LAT=2 and L=11/LAT=3)
module tb_fft_agu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start_g = 1'b0;

    logic        busy, done, rd_en, wr_en;
    logic [1:0]  level;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0]  tw_addr;

    logic        busy_g, done_g, rd_en_g, wr_en_g;
    logic [3:0]  level_g;
    logic [10:0] rd_addr_a_g, rd_addr_b_g, wr_addr_a_g, wr_addr_b_g;
    logic [9:0]  tw_addr_g;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    always #5 clk = ~clk;

    fft_agu #(.L(3), .BUTTERFLY_LAT(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .level(level), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_agu #(.L(11), .BUTTERFLY_LAT(3)) u_big (
        .clk(clk), .reset_n(reset_n), .start(start_g), .busy(busy_g), .done(done_g),
        .level(level_g), .rd_en(rd_en_g), .rd_addr_a(rd_addr_a_g), .rd_addr_b(rd_addr_b_g),
        .tw_addr(tw_addr_g), .wr_en(wr_en_g), .wr_addr_a(wr_addr_a_g), .wr_addr_b(wr_addr_b_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit small_rd(input int c);
        if (c < 1 || c > 18) return 1'b0;
        return ((c - 1) % 6) < 4;
    endfunction

    function automatic int small_idx(input int c);
        return ((c - 1) / 6) * 4 + (c - 1) % 6;
    endfunction

    // Called at a negedge; start is seen by the following posedge (cycle 0).
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_trace(input string name, input int glitch_at, input bit chain);
        bit re, we;
        int idx, n_wr;
        n_wr = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            re = small_rd(c);
            we = small_rd(c - 2);
            chk($sformatf("%s rd_en c%0d", name, c), rd_en, re);
            if (re) begin
                idx = small_idx(c);
                chk($sformatf("%s rd_a c%0d", name, c), rd_addr_a, exp_a[idx]);
                chk($sformatf("%s rd_b c%0d", name, c), rd_addr_b, exp_b[idx]);
                chk($sformatf("%s tw c%0d", name, c), tw_addr, exp_tw[idx]);
                chk($sformatf("%s level c%0d", name, c), level, idx / 4);
            end
            chk($sformatf("%s wr_en c%0d", name, c), wr_en, we);
            if (we) begin
                idx = small_idx(c - 2);
                chk($sformatf("%s wr_a c%0d", name, c), wr_addr_a, exp_a[idx]);
                chk($sformatf("%s wr_b c%0d", name, c), wr_addr_b, exp_b[idx]);
            end
            if (wr_en === 1'b1) n_wr++;
            chk($sformatf("%s busy c%0d", name, c), busy, c <= 19);
            chk($sformatf("%s done c%0d", name, c), done, c == 19);
            if (c == glitch_at) start = 1'b1;
            else if (c == glitch_at + 1) start = 1'b0;
            if (chain && c == 19) start = 1'b1;
        end
        chk($sformatf("%s wr_count", name), n_wr, 12);
    endtask

    initial begin
        bit re, we;
        int lvl, pos, ma, mb, mt, err, n_rd, n_wr, n_done, done_c, any_act;
        int hit_a, hit_b, hit_t, hit_l;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_en", rd_en, 0);
        chk("reset wr_en", wr_en, 0);
        chk("reset rd_addr_b", rd_addr_b, 0);
        chk("reset level", level, 0);
        chk("reset big busy", busy_g, 0);
        reset_n = 1'b1;

        @(negedge clk);
        pulse_start();
        run_trace("t1", -1, 1'b0);

        pulse_start();
        run_trace("t3", 8, 1'b0);

        // Abort in the middle of level 1.
        pulse_start();
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t4 rst rd_en", rd_en, 0);
        chk("t4 rst busy", busy, 0);
        chk("t4 rst wr_en", wr_en, 0);
        chk("t4 rst rd_addr_a", rd_addr_a, 0);
        chk("t4 rst tw", tw_addr, 0);
        chk("t4 rst level", level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        any_act = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) any_act++;
        end
        chk("t4 quiet after release", any_act, 0);
        pulse_start();
        run_trace("t4 rerun", -1, 1'b0);

        // Start held through the DONE cycle and into the following idle cycle.
        pulse_start();
        run_trace("t5a", -1, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        run_trace("t5b", -1, 1'b0);

        // Full-size run checked against an independent index model.
        @(negedge clk);
        start_g = 1'b1;
        @(posedge clk);
        #1 start_g = 1'b0;
        err = 0; n_rd = 0; n_wr = 0; n_done = 0; done_c = -1;
        hit_a = -1; hit_b = -1; hit_t = -1; hit_l = -1;
        for (int c = 1; c <= 11300; c++) begin
            @(negedge clk);
            lvl = (c - 1) / 1027;
            pos = (c - 1) % 1027;
            re  = (c <= 11297) && (pos < 1024);
            ma  = ((pos >> lvl) << (lvl + 1)) + (pos % (1 << lvl));
            mb  = ma + (1 << lvl);
            mt  = (pos % (1 << lvl)) * (1024 >> lvl);
            if (rd_en_g !== re) err++;
            else if (re && (rd_addr_a_g !== ma[10:0] || rd_addr_b_g !== mb[10:0] ||
                            tw_addr_g !== mt[9:0] || level_g !== lvl[3:0])) err++;
            lvl = (c - 4) / 1027;
            pos = (c - 4) % 1027;
            we  = (c >= 4) && (c <= 11300) && (pos < 1024) && (lvl < 11);
            ma  = ((pos >> lvl) << (lvl + 1)) + (pos % (1 << lvl));
            mb  = ma + (1 << lvl);
            if (wr_en_g !== we) err++;
            else if (we && (wr_addr_a_g !== ma[10:0] || wr_addr_b_g !== mb[10:0])) err++;
            if (rd_en_g === 1'b1) n_rd++;
            if (wr_en_g === 1'b1) n_wr++;
            if (done_g === 1'b1) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (c == 11294) begin
                hit_a = int'(rd_addr_a_g);
                hit_b = int'(rd_addr_b_g);
                hit_t = int'(tw_addr_g);
                hit_l = int'(level_g);
            end
        end
        chk("t6 pair errors", err, 0);
        chk("t6 rd count", n_rd, 11264);
        chk("t6 wr count", n_wr, 11264);
        chk("t6 done cycle", done_c, 11298);
        chk("t6 done pulses", n_done, 1);
        chk("t6 last rd_a", hit_a, 1023);
        chk("t6 last rd_b", hit_b, 2047);
        chk("t6 last tw", hit_t, 1023);
        chk("t6 last level", hit_l, 10);
        chk("t6 busy after", busy_g, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
